vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised raster timing generator producing horizontal/vertical sync, pixel coordinates, a blanking qualifier and line/frame strobes for the display path. Both axes use the same four-phase timing (active, front porch, sync pulse, back porch), with sync polarity, pixel-rate enable and start/stop control all configurable. It sits between the pixel clock domain logic and the VGA DAC/connector pins, and feeds coordinates to the framebuffer read logic.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch (pixels)
- H_PULSE, 96: horizontal sync width (pixels)
- H_BP, 48: horizontal back porch (pixels)
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch (lines)
- V_PULSE, 2: vertical sync width (lines)
- V_BP, 33: vertical back porch (lines)
- H_POL, 1'b0: h_sync active level (0 = active-low)
- V_POL, 1'b0: v_sync active level
- CNT_W, 10: width of h_count and v_count
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- en  input  1  run request; 0 = idle (blanked, syncs inactive)
- pix_en  input  1  pixel-rate tick; state advances only on clk edges with pix_en=1
- h_count  output  CNT_W  current pixel column, 0..H_TOTAL-1
- v_count  output  CNT_W  current line, 0..V_TOTAL-1
- h_sync  output  1  horizontal sync, level per H_POL
- v_sync  output  1  vertical sync, level per V_POL
- video_on  output  1  1 when h_count < H_ACTIVE and v_count < V_ACTIVE while running
- new_line  output  1  one-clk pulse when h_count enters 0
- new_frame  output  1  one-clk pulse when (h_count,v_count) enters (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_PULSE+H_BP; V_TOTAL likewise. Elaboration error if H_TOTAL-1 or V_TOTAL-1 does not fit in CNT_W, or any parameter is 0.
- Control FSM, two states: IDLE, RUN.
- IDLE: counters 0, h_sync=~H_POL, v_sync=~V_POL, video_on=0. On clk with en=1 and pix_en=1 -> RUN; position stays (0,0), outputs decoded for (0,0), new_line=new_frame=1.
- RUN, pix_en=1: h_count increments; at H_TOTAL-1 wraps to 0 and v_count increments; v_count at V_TOTAL-1 with h wrap wraps to 0.
- RUN, en=0: next clk edge -> IDLE regardless of pix_en or position (abrupt stop, no frame completion).
- h_sync active iff H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_PULSE; v_sync active iff V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_PULSE. Output level = active ? POL : ~POL.
- Per-axis phase (ACTIVE/FRONT/SYNC/BACK) tracked as registered state updated with the counter; decode uses the phase, not wide comparators on outputs.
- Comparisons done at CNT_W+1 bits; no overflow wrap-around in boundary sums.

## Timing
- All outputs registered; h_count, v_count, h_sync, v_sync, video_on change on the same clk edge and are mutually consistent every cycle (zero skew between coordinates and qualifiers).
- v_sync and v_count change only on the edge where h_count wraps to 0.
- new_line/new_frame high exactly one clk cycle after the advancing edge, even when pix_en is held high continuously; 0 otherwise.
- pix_en=0: all outputs hold, except strobes, which return to 0.
- Reset: IDLE, h_count=0, v_count=0, h_sync=~H_POL, v_sync=~V_POL, video_on=0, new_line=0, new_frame=0. rst has priority over en and pix_en; reset mid-frame returns to these values on the next edge.

## Structure
- Package vga_timing_pkg: phase_t enum {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK}, ctrl_t enum {ST_IDLE, ST_RUN}, default 640x480@60 timing constants.
- Sub-module timing_axis (params ACTIVE, FP, PULSE, BP, POL, CNT_W; inputs clk, rst, clr, step; outputs count, phase, sync, wrap), instantiated twice: horizontal steps on pix_en in RUN, vertical steps on horizontal wrap.

## Test plan
- Defaults, rst then en=1, pix_en=1 every clk: h_sync low exactly for h_count 656..751, new_line every 800 clks, v_sync low for v_count 490..491, new_frame every 420000 clks.
- Small params H=4/1/2/1, V=3/1/1/1, H_POL=V_POL=1: h_sync high at h_count 5..6, total 8; v_sync high at v_count 4; video_on count per frame = 12.
- pix_en every 4th clk: coordinates advance once per 4 clks, strobes one clk wide, frame = 4x clks.
- en dropped at (300,200): next edge counters (0,0), video_on=0, syncs inactive; re-raise en -> new_frame pulse, video_on=1 at (0,0).
- rst asserted at (799,524) with pix_en=1: next edge matches reset values; no wrap strobe emitted.
- Check across all cycles: video_on==(h_count<H_ACTIVE && v_count<V_ACTIVE) while RUN, and h_count<H_TOTAL, v_count<V_TOTAL.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 timing constants for the raster timing generator.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } ctrl_t;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_PULSE  = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_PULSE  = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_CNT_W    = 10;

    // Pin level of a sync signal given whether the pulse is active and its polarity.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis: position counter plus registered phase and sync level.
// The wrap output is combinational so the next axis can step on the same edge.
module timing_axis
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned PULSE  = DEF_H_PULSE,
    parameter int unsigned BP     = DEF_H_BP,
    parameter logic        POL    = 1'b0,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output phase_t           phase,
    output logic             sync,
    output logic             wrap,
    output phase_t           phase_nxt_c
);

    localparam int unsigned TOTAL = ACTIVE + FP + PULSE + BP;
    localparam int unsigned EXT_W = CNT_W + 1;

    // Boundaries held one bit wider than the counter so sums never wrap.
    localparam logic [EXT_W-1:0] FRONT_START = EXT_W'(ACTIVE);
    localparam logic [EXT_W-1:0] SYNC_START  = EXT_W'(ACTIVE + FP);
    localparam logic [EXT_W-1:0] BACK_START  = EXT_W'(ACTIVE + FP + PULSE);
    localparam logic [EXT_W-1:0] LAST        = EXT_W'(TOTAL - 1);

    if (ACTIVE == 0 || FP == 0 || PULSE == 0 || BP == 0) begin : g_zero_param
        $error("timing_axis: every phase length must be non-zero");
    end

    if (CNT_W == 0 || CNT_W > 31 || ((TOTAL - 1) >> CNT_W) != 0) begin : g_cnt_w
        $error("timing_axis: TOTAL-1 does not fit in CNT_W bits");
    end

    logic [EXT_W-1:0] count_ext;
    logic [EXT_W-1:0] count_inc;
    logic [CNT_W-1:0] count_nxt;

    // Next position and phase; phase moves only when the counter crosses a boundary.
    always_comb begin
        count_ext   = {1'b0, count};
        count_inc   = count_ext + EXT_W'(1);
        wrap        = step && !clr && (count_ext == LAST);
        count_nxt   = count;
        phase_nxt_c = phase;
        if (clr || wrap) begin
            count_nxt   = '0;
            phase_nxt_c = PH_ACTIVE;
        end else if (step) begin
            count_nxt = count_inc[CNT_W-1:0];
            case (phase)
                PH_ACTIVE: if (count_inc == FRONT_START) phase_nxt_c = PH_FRONT;
                PH_FRONT:  if (count_inc == SYNC_START)  phase_nxt_c = PH_SYNC;
                PH_SYNC:   if (count_inc == BACK_START)  phase_nxt_c = PH_BACK;
                default:   phase_nxt_c = phase;  // back porch ends only through wrap
            endcase
        end
    end

    // Counter, phase and sync level update together so they never skew.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            phase <= PH_ACTIVE;
            sync  <= sync_level(1'b0, POL);
        end else begin
            count <= count_nxt;
            phase <= phase_nxt_c;
            sync  <= sync_level(phase_nxt_c == PH_SYNC, POL);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: run/idle control around a horizontal and a vertical axis,
// with registered blanking qualifier and line/frame strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_PULSE  = DEF_H_PULSE,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_PULSE  = DEF_V_PULSE,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        H_POL    = 1'b0,
    parameter logic        V_POL    = 1'b0,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pix_en,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             h_sync,
    output logic             v_sync,
    output logic             video_on,
    output logic             new_line,
    output logic             new_frame
);

    ctrl_t  state;
    ctrl_t  state_nxt;
    logic   axis_clr;
    logic   h_step;
    logic   h_wrap;
    logic   v_wrap;
    phase_t h_phase;
    phase_t v_phase;
    phase_t h_phase_nxt;
    phase_t v_phase_nxt;
    logic   video_on_nxt;
    logic   new_line_nxt;
    logic   new_frame_nxt;

    timing_axis #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .PULSE  (H_PULSE),
        .BP     (H_BP),
        .POL    (H_POL),
        .CNT_W  (CNT_W)
    ) u_h_axis (
        .clk         (clk),
        .rst         (rst),
        .clr         (axis_clr),
        .step        (h_step),
        .count       (h_count),
        .phase       (h_phase),
        .sync        (h_sync),
        .wrap        (h_wrap),
        .phase_nxt_c (h_phase_nxt)
    );

    timing_axis #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .PULSE  (V_PULSE),
        .BP     (V_BP),
        .POL    (V_POL),
        .CNT_W  (CNT_W)
    ) u_v_axis (
        .clk         (clk),
        .rst         (rst),
        .clr         (axis_clr),
        .step        (h_wrap),
        .count       (v_count),
        .phase       (v_phase),
        .sync        (v_sync),
        .wrap        (v_wrap),
        .phase_nxt_c (v_phase_nxt)
    );

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next control state and axis controls; idle holds both axes at (0,0).
    always_comb begin
        state_nxt = state;
        axis_clr  = 1'b0;
        h_step    = 1'b0;
        case (state)
            ST_IDLE: begin
                axis_clr = 1'b1;
                if (en && pix_en) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                    axis_clr  = 1'b1;
                end else begin
                    h_step = pix_en;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                axis_clr  = 1'b1;
            end
        endcase
    end

    // Qualifier and strobe next values, decoded from the axes' next phases and wraps.
    always_comb begin
        video_on_nxt  = 1'b0;
        new_line_nxt  = 1'b0;
        new_frame_nxt = 1'b0;
        if (state == ST_IDLE && state_nxt == ST_RUN) begin
            new_line_nxt  = 1'b1;
            new_frame_nxt = 1'b1;
        end else begin
            new_line_nxt  = h_wrap;
            new_frame_nxt = h_wrap && v_wrap;
        end
        video_on_nxt = (state_nxt == ST_RUN) && (h_phase_nxt == PH_ACTIVE)
                       && (v_phase_nxt == PH_ACTIVE);
    end

    // Registered qualifier and strobes, aligned with the axis registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            video_on  <= 1'b0;
            new_line  <= 1'b0;
            new_frame <= 1'b0;
        end else begin
            video_on  <= video_on_nxt;
            new_line  <= new_line_nxt;
            new_frame <= new_frame_nxt;
        end
    end

    // While idle both axes must be parked at the start of the active region.
    a_idle_parked: assert property (@(posedge clk) disable iff (rst)
        (state == ST_IDLE) |-> (h_phase == PH_ACTIVE && v_phase == PH_ACTIVE));

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing and a small-timing instance, each checked
// every cycle against a behavioural model through a scoreboard queue.
module tb_vga_timing_gen;

    localparam int unsigned CW = 10;

    typedef struct {
        int ha; int hfp; int hp; int hbp;
        int va; int vfp; int vp; int vbp;
        bit hpol; bit vpol;
    } cfg_t;

    typedef struct {
        bit run; int h; int v; bit nl; bit nf;
    } mdl_t;

    logic clk = 1'b0;
    logic rst_d, en_d, pix_d;
    logic rst_s, en_s, pix_s;
    logic [CW-1:0] hc_d, vc_d, hc_s, vc_s;
    logic hs_d, vs_d, vo_d, nl_d, nf_d;
    logic hs_s, vs_s, vo_s, nl_s, nf_s;
    logic [24:0] obs_d, obs_s;

    int n_checks = 0;
    int n_fail   = 0;
    logic [24:0] q_d[$];
    logic [24:0] q_s[$];
    cfg_t cfg_d, cfg_s;
    mdl_t md, ms;

    assign obs_d = {hc_d, vc_d, hs_d, vs_d, vo_d, nl_d, nf_d};
    assign obs_s = {hc_s, vc_s, hs_s, vs_s, vo_s, nl_s, nf_s};

    always #5 clk = ~clk;

    vga_timing_gen dut_def (
        .clk(clk), .rst(rst_d), .en(en_d), .pix_en(pix_d),
        .h_count(hc_d), .v_count(vc_d), .h_sync(hs_d), .v_sync(vs_d),
        .video_on(vo_d), .new_line(nl_d), .new_frame(nf_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_PULSE(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_PULSE(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .CNT_W(CW)
    ) dut_sml (
        .clk(clk), .rst(rst_s), .en(en_s), .pix_en(pix_s),
        .h_count(hc_s), .v_count(vc_s), .h_sync(hs_s), .v_sync(vs_s),
        .video_on(vo_s), .new_line(nl_s), .new_frame(nf_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: one clock edge given the inputs present before it.
    task automatic model_step(input cfg_t c, input mdl_t mi, input logic r, input logic e,
                              input logic p, output mdl_t mo, output logic [24:0] ex);
        int  ht, vt;
        bit  hs_a, vs_a, vo;
        ht = c.ha + c.hfp + c.hp + c.hbp;
        vt = c.va + c.vfp + c.vp + c.vbp;
        mo = mi;
        mo.nl = 1'b0;
        mo.nf = 1'b0;
        if (r) begin
            mo.run = 1'b0; mo.h = 0; mo.v = 0;
        end else if (!mi.run) begin
            mo.h = 0; mo.v = 0;
            if (e && p) begin
                mo.run = 1'b1; mo.nl = 1'b1; mo.nf = 1'b1;
            end
        end else if (!e) begin
            mo.run = 1'b0; mo.h = 0; mo.v = 0;
        end else if (p) begin
            mo.h = mi.h + 1;
            if (mo.h == ht) begin
                mo.h = 0;
                mo.v = mi.v + 1;
                if (mo.v == vt) mo.v = 0;
            end
            mo.nl = (mo.h == 0);
            mo.nf = (mo.h == 0) && (mo.v == 0);
        end
        hs_a = mo.run && (mo.h >= c.ha + c.hfp) && (mo.h < c.ha + c.hfp + c.hp);
        vs_a = mo.run && (mo.v >= c.va + c.vfp) && (mo.v < c.va + c.vfp + c.vp);
        vo   = mo.run && (mo.h < c.ha) && (mo.v < c.va);
        ex = {10'(mo.h), 10'(mo.v), hs_a ? c.hpol : ~c.hpol, vs_a ? c.vpol : ~c.vpol,
              vo, mo.nl, mo.nf};
    endtask

    // Predict, advance one clock, then compare both instances against the queue heads.
    task automatic tick();
        mdl_t        nxt;
        logic [24:0] e;
        model_step(cfg_d, md, rst_d, en_d, pix_d, nxt, e);
        md = nxt;
        q_d.push_back(e);
        model_step(cfg_s, ms, rst_s, en_s, pix_s, nxt, e);
        ms = nxt;
        q_s.push_back(e);
        @(posedge clk);
        #1;
        check("def_cycle", 32'(obs_d), 32'(q_d.pop_front()));
        check("sml_cycle", 32'(obs_s), 32'(q_s.pop_front()));
    endtask

    initial begin
        int nl_cnt, nf_cnt, hs_low, hs_first, hs_last, vs_low, last_nl;
        int vo_cnt, vs_hi, hs_hi, found;

        cfg_d = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
        cfg_s = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};
        md = '{1'b0, 0, 0, 1'b0, 1'b0};
        ms = '{1'b0, 0, 0, 1'b0, 1'b0};
        rst_d = 1'b1; en_d = 1'b1; pix_d = 1'b1;
        rst_s = 1'b1; en_s = 1'b1; pix_s = 1'b1;
        tick();
        tick();
        check("def_reset", 32'(obs_d), 32'h18);
        check("sml_reset", 32'(obs_s), 32'h0);

        // Default timing, continuous pixel rate, a little over two lines.
        rst_d = 1'b0;
        tick();
        check("def_start_nl", 32'(nl_d), 32'd1);
        check("def_start_vo", 32'(vo_d), 32'd1);
        nl_cnt = 0; nf_cnt = 0; hs_low = 0; hs_first = -1; hs_last = -1; vs_low = 0; last_nl = 0;
        for (int i = 1; i <= 1700; i++) begin
            tick();
            if (nl_d) begin nl_cnt++; last_nl = i; end
            if (nf_d) nf_cnt++;
            if (!vs_d) vs_low++;
            if (!hs_d) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(hc_d);
                hs_last = int'(hc_d);
            end
        end
        check("def_nl_count", 32'(nl_cnt), 32'd2);
        check("def_nl_period", 32'(last_nl), 32'd1600);
        check("def_nf_none", 32'(nf_cnt), 32'd0);
        check("def_hs_low_cycles", 32'(hs_low), 32'd192);
        check("def_hs_first", 32'(hs_first), 32'd656);
        check("def_hs_last", 32'(hs_last), 32'd751);
        check("def_vs_quiet", 32'(vs_low), 32'd0);

        // Small timing, continuous pixel rate, one full frame.
        rst_s = 1'b0; en_s = 1'b1; pix_s = 1'b1;
        tick();
        check("sml_start_nf", 32'(nf_s), 32'd1);
        vo_cnt = 0; vs_hi = 0; hs_hi = 0; nl_cnt = 0;
        for (int i = 0; i < 48; i++) begin
            if (vo_s) vo_cnt++;
            if (vs_s) vs_hi++;
            if (hs_s) hs_hi++;
            if (nl_s) nl_cnt++;
            tick();
        end
        check("sml_frame_period", 32'(nf_s), 32'd1);
        check("sml_vo_per_frame", 32'(vo_cnt), 32'd12);
        check("sml_vs_hi_cycles", 32'(vs_hi), 32'd8);
        check("sml_hs_hi_cycles", 32'(hs_hi), 32'd12);
        check("sml_nl_per_frame", 32'(nl_cnt), 32'd6);

        // Small timing, pixel tick every fourth clock.
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        tick();
        found = 0; nl_cnt = 0;
        for (int i = 1; i <= 400; i++) begin
            pix_s = (i % 4 == 0);
            tick();
            if (nl_s) nl_cnt++;
            if (nf_s) begin found = i; break; end
        end
        check("sml_slow_frame", 32'(found), 32'd192);
        check("sml_slow_lines", 32'(nl_cnt), 32'd6);

        // Abrupt stop mid-frame, hold on pix_en=0 first, then restart.
        pix_s = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (hc_s == 10'd3 && vc_s == 10'd2) break;
            tick();
        end
        check("sml_reach_3_2", 32'({hc_s, vc_s}), 32'({10'd3, 10'd2}));
        pix_s = 1'b0;
        tick();
        check("sml_hold_h", 32'(hc_s), 32'd3);
        check("sml_hold_vo", 32'(vo_s), 32'd1);
        en_s = 1'b0;
        tick();
        check("sml_stop_pos", 32'({hc_s, vc_s}), 32'd0);
        check("sml_stop_vo", 32'(vo_s), 32'd0);
        check("sml_stop_sync", 32'({hs_s, vs_s}), 32'd0);
        tick();
        en_s = 1'b1; pix_s = 1'b1;
        tick();
        check("sml_restart_nf", 32'(nf_s), 32'd1);
        check("sml_restart_vo", 32'(vo_s), 32'd1);

        // Reset on the last position of the frame with pixel tick high.
        for (int k = 0; k < 100; k++) begin
            if (hc_s == 10'd7 && vc_s == 10'd5) break;
            tick();
        end
        check("sml_reach_last", 32'({hc_s, vc_s}), 32'({10'd7, 10'd5}));
        rst_s = 1'b1;
        tick();
        check("sml_rst_last", 32'(obs_s), 32'h0);
        rst_s = 1'b0;
        for (int k = 0; k < 20; k++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
